// File: rtl/uart_tx_fsm_pkg.sv
// Shared types and constants for the UART transmit frame sequencer.
package uart_tx_fsm_pkg;

    localparam int unsigned STATE_W = 5;
    localparam int unsigned CNT_W   = 4;

    // One-hot frame states; the encoding is shared with the TX shift register.
    typedef enum logic [STATE_W-1:0] {
        ST_INTERVAL  = 5'b00001,
        ST_STARTBIT  = 5'b00010,
        ST_DATABITS  = 5'b00100,
        ST_PARITYBIT = 5'b01000,
        ST_STOPBIT   = 5'b10000
    } tx_state_e;

    localparam logic [CNT_W-1:0] BIT0     = CNT_W'(0);
    localparam logic             NONEMPTY = 1'b0;

    // Frame configuration captured when a frame starts.
    typedef struct packed {
        logic parity_en;
        logic two_stop;
    } tx_cfg_t;

    // FIFO-read / frame-start condition; the shift register uses the same function.
    function automatic logic start_frame(input logic baud_tick, input logic fifo_empty);
        return baud_tick && (fifo_empty == NONEMPTY);
    endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Control/status bundle between the frame sequencer and its environment.
interface uart_tx_fsm_if;
    import uart_tx_fsm_pkg::*;

    logic               p_BaudSig_i;
    logic               p_FiFoEmpty_i;
    logic               p_ParityEn_i;
    logic               p_TwoStop_i;
    logic               p_Abort_i;
    logic [STATE_W-1:0] State_o;
    logic [CNT_W-1:0]   BitCounter_o;
    logic               p_ParityCalTrigger_o;
    logic               p_TxBusy_o;
    logic               p_FrameDone_o;

    // Sequencer side.
    modport slave (
        input  p_BaudSig_i, p_FiFoEmpty_i, p_ParityEn_i, p_TwoStop_i, p_Abort_i,
        output State_o, BitCounter_o, p_ParityCalTrigger_o, p_TxBusy_o, p_FrameDone_o
    );

    // Environment side (baud generator, FIFO, host).
    modport master (
        output p_BaudSig_i, p_FiFoEmpty_i, p_ParityEn_i, p_TwoStop_i, p_Abort_i,
        input  State_o, BitCounter_o, p_ParityCalTrigger_o, p_TxBusy_o, p_FrameDone_o
    );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: one-hot frame state, data-bit index,
// parity-latch trigger and busy/done status. All outputs registered.
module uart_tx_fsm
    import uart_tx_fsm_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_fsm_if.slave tx_if
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    tx_cfg_t          cfg_q, cfg_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic             abort_q, abort_d;
    logic             par_trig_q, par_trig_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             tick;
    logic             abort_now;

    assign tick      = tx_if.p_BaudSig_i;
    // A request arriving in the same clk as a tick acts on that tick.
    assign abort_now = abort_q | tx_if.p_Abort_i;

    // State and status registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INTERVAL;
            bit_cnt_q  <= BIT0;
            cfg_q      <= '0;
            stop_cnt_q <= 1'b0;
            abort_q    <= 1'b0;
            par_trig_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cfg_q      <= cfg_d;
            stop_cnt_q <= stop_cnt_d;
            abort_q    <= abort_d;
            par_trig_q <= par_trig_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, bit index, stop counter, abort latch and pulse generation.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cfg_d      = cfg_q;
        stop_cnt_d = stop_cnt_q;
        abort_d    = abort_now;
        par_trig_d = 1'b0;
        done_d     = 1'b0;

        // Every tick consumes a pending abort, whether or not it had any effect.
        if (tick) begin
            abort_d = 1'b0;
        end

        case (state_q)
            ST_INTERVAL: begin
                if (start_frame(tick, tx_if.p_FiFoEmpty_i)) begin
                    state_d         = ST_STARTBIT;
                    bit_cnt_d       = BIT0;
                    cfg_d.parity_en = tx_if.p_ParityEn_i;
                    cfg_d.two_stop  = tx_if.p_TwoStop_i;
                end
            end

            ST_STARTBIT: begin
                if (tick) begin
                    bit_cnt_d = BIT0;
                    if (abort_now) begin
                        state_d    = ST_STOPBIT;
                        stop_cnt_d = 1'b0;
                    end else begin
                        // Shift data is stable by now; let the parity generator sample it.
                        state_d    = ST_DATABITS;
                        par_trig_d = 1'b1;
                    end
                end
            end

            ST_DATABITS: begin
                if (tick) begin
                    if (abort_now) begin
                        state_d    = ST_STOPBIT;
                        bit_cnt_d  = BIT0;
                        stop_cnt_d = 1'b0;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        if (cfg_q.parity_en) begin
                            // Index holds the last bit through the parity slot.
                            state_d = ST_PARITYBIT;
                        end else begin
                            state_d    = ST_STOPBIT;
                            bit_cnt_d  = BIT0;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_PARITYBIT: begin
                if (tick) begin
                    state_d    = ST_STOPBIT;
                    bit_cnt_d  = BIT0;
                    stop_cnt_d = 1'b0;
                end
            end

            ST_STOPBIT: begin
                if (tick) begin
                    // One stop tick when two_stop=0, two when two_stop=1.
                    if (stop_cnt_q == cfg_q.two_stop) begin
                        state_d    = ST_INTERVAL;
                        stop_cnt_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end

            default: begin
                // Corrupted (non-one-hot) state: recover immediately, no tick needed.
                state_d    = ST_INTERVAL;
                bit_cnt_d  = BIT0;
                stop_cnt_d = 1'b0;
                abort_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_INTERVAL);
    end

    assign tx_if.State_o              = state_q;
    assign tx_if.BitCounter_o         = bit_cnt_q;
    assign tx_if.p_ParityCalTrigger_o = par_trig_q;
    assign tx_if.p_FrameDone_o        = done_q;
    assign tx_if.p_TxBusy_o           = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: an 8-bit and a 7-bit instance share
// stimulus and are compared each clk against a frame-position reference model.
module tb_uart_tx_fsm;

    logic clk = 1'b0;
    logic rst, baud, fifo_empty, par_en, two_stop, abort;

    always #5 clk = ~clk;

    uart_tx_fsm_if bus8 ();
    uart_tx_fsm_if bus7 ();

    assign bus8.p_BaudSig_i   = baud;
    assign bus8.p_FiFoEmpty_i = fifo_empty;
    assign bus8.p_ParityEn_i  = par_en;
    assign bus8.p_TwoStop_i   = two_stop;
    assign bus8.p_Abort_i     = abort;
    assign bus7.p_BaudSig_i   = baud;
    assign bus7.p_FiFoEmpty_i = fifo_empty;
    assign bus7.p_ParityEn_i  = par_en;
    assign bus7.p_TwoStop_i   = two_stop;
    assign bus7.p_Abort_i     = abort;

    uart_tx_fsm #(.DATA_BITS(8)) dut8 (.clk(clk), .rst(rst), .tx_if(bus8));
    uart_tx_fsm #(.DATA_BITS(7)) dut7 (.clk(clk), .rst(rst), .tx_if(bus7));

    // Observation vector: {state[4:0], bitcnt[3:0], trig, done, busy}
    localparam logic [11:0] IDLE_V = 12'b00001_0000_000;
    logic [11:0] obs [2];
    assign obs[0] = {bus8.State_o, bus8.BitCounter_o, bus8.p_ParityCalTrigger_o,
                     bus8.p_FrameDone_o, bus8.p_TxBusy_o};
    assign obs[1] = {bus7.State_o, bus7.BitCounter_o, bus7.p_ParityCalTrigger_o,
                     bus7.p_FrameDone_o, bus7.p_TxBusy_o};

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position (in baud ticks) inside the current frame.
    bit          m_act  [2];
    int          m_pos  [2];
    bit          m_par  [2];
    bit          m_two  [2];
    bit          m_pend [2];
    bit          m_trig [2];
    bit          m_done [2];
    logic [11:0] exp_v  [2];
    int          cd = 0;

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int n;
            int s_idx;
            int t_len;
            logic [4:0] st;
            logic [3:0] cn;
            n = (k == 0) ? 8 : 7;
            m_trig[k] = 1'b0;
            m_done[k] = 1'b0;
            if (rst) begin
                m_act[k] = 1'b0; m_pos[k] = 0; m_pend[k] = 1'b0;
                m_par[k] = 1'b0; m_two[k] = 1'b0;
            end else if (baud) begin
                if (!m_act[k]) begin
                    if (!fifo_empty) begin
                        m_act[k] = 1'b1; m_pos[k] = 0;
                        m_par[k] = par_en; m_two[k] = two_stop;
                    end
                end else begin
                    s_idx = 1 + n + (m_par[k] ? 1 : 0);
                    t_len = s_idx + (m_two[k] ? 2 : 1);
                    if ((m_pend[k] || abort) && m_pos[k] < s_idx) m_pos[k] = s_idx;
                    else m_pos[k] = m_pos[k] + 1;
                    if (m_pos[k] == t_len) begin
                        m_act[k]  = 1'b0;
                        m_done[k] = 1'b1;
                    end
                end
                m_pend[k] = 1'b0;
                m_trig[k] = m_act[k] && (m_pos[k] == 1);
            end else if (abort) begin
                m_pend[k] = 1'b1;
            end
            if (!m_act[k])                                   begin st = 5'b00001; cn = 4'd0; end
            else if (m_pos[k] == 0)                          begin st = 5'b00010; cn = 4'd0; end
            else if (m_pos[k] <= n)                          begin st = 5'b00100; cn = 4'(m_pos[k] - 1); end
            else if (m_par[k] && m_pos[k] == n + 1)          begin st = 5'b01000; cn = 4'(n - 1); end
            else                                             begin st = 5'b10000; cn = 4'd0; end
            exp_v[k] = {st, cn, m_trig[k], m_done[k], m_act[k]};
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Baud ticks every 2..4 clks.
    task automatic drive_baud();
        if (cd == 0) begin
            baud = 1'b1;
            cd   = int'($urandom_range(1, 3));
        end else begin
            baud = 1'b0;
            cd   = cd - 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; baud = 1'b1; fifo_empty = 1'b0; par_en = 1'b1; two_stop = 1'b1; abort = 1'b1;
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== IDLE_V) begin
                n_err++;
                $display("FAIL reset_state dut%0d got %b want %b", k, obs[k], IDLE_V);
            end
        end
        rst = 1'b0; fifo_empty = 1'b1; abort = 1'b0; par_en = 1'b0; two_stop = 1'b0;
        for (int c = 0; c < 70; c++) begin
            drive_baud();
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== exp_v[k] || obs[k] !== IDLE_V) begin
                    n_err++;
                    $display("FAIL idle_empty dut%0d t=%0t got %b want %b", k, $time, obs[k], exp_v[k]);
                end
            end
        end
    endtask

    task automatic drain(input string name);
        fifo_empty = 1'b1; abort = 1'b0;
        for (int c = 0; c < 80; c++) begin
            drive_baud();
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== exp_v[k]) begin
                    n_err++;
                    $display("FAIL %s_drain dut%0d t=%0t got %b want %b", name, k, $time, obs[k], exp_v[k]);
                end
            end
        end
    endtask

    task automatic test_basic_frame();
        int dones = 0, trigs = 0, maxcnt = 0;
        par_en = 1'b0; two_stop = 1'b0; fifo_empty = 1'b0; abort = 1'b0;
        for (int c = 0; c < 80; c++) begin
            drive_baud();
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== exp_v[k]) begin
                    n_err++;
                    $display("FAIL basic_frame dut%0d t=%0t got %b want %b", k, $time, obs[k], exp_v[k]);
                end
            end
            if (obs[0][0]) fifo_empty = 1'b1;
            if (obs[0][1]) dones++;
            if (obs[0][2]) trigs++;
            if (obs[0][11:7] == 5'b00100 && int'(obs[0][6:3]) > maxcnt) maxcnt = int'(obs[0][6:3]);
        end
        n_cmp++;
        if (dones != 1) begin n_err++; $display("FAIL basic_done_count got %0d want 1", dones); end
        n_cmp++;
        if (trigs != 1) begin n_err++; $display("FAIL basic_trig_count got %0d want 1", trigs); end
        n_cmp++;
        if (maxcnt != 7) begin n_err++; $display("FAIL basic_bitcnt_peak got %0d want 7", maxcnt); end
        drain("basic");
    endtask

    task automatic test_parity_two_stop();
        int busy_ticks = 0, maxcnt = 0;
        bit started = 1'b0;
        par_en = 1'b1; two_stop = 1'b1; fifo_empty = 1'b0; abort = 1'b0;
        for (int c = 0; c < 90; c++) begin
            drive_baud();
            if (started) begin
                par_en   = 1'($urandom_range(0, 1));
                two_stop = 1'($urandom_range(0, 1));
            end
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== exp_v[k]) begin
                    n_err++;
                    $display("FAIL parity_frame dut%0d t=%0t got %b want %b", k, $time, obs[k], exp_v[k]);
                end
            end
            if (obs[1][0]) begin started = 1'b1; fifo_empty = 1'b1; end
            if (baud && obs[1][0]) busy_ticks++;
            if (obs[1][11:7] == 5'b00100 && int'(obs[1][6:3]) > maxcnt) maxcnt = int'(obs[1][6:3]);
        end
        n_cmp++;
        if (busy_ticks != 11) begin n_err++; $display("FAIL parity_busy_ticks got %0d want 11", busy_ticks); end
        n_cmp++;
        if (maxcnt != 6) begin n_err++; $display("FAIL parity_bitcnt_peak got %0d want 6", maxcnt); end
        par_en = 1'b0; two_stop = 1'b0;
        drain("parity");
    endtask

    task automatic test_back_to_back();
        int ticks = 0, dones = 0, idle_ticks = 0;
        par_en = 1'b0; two_stop = 1'b0; fifo_empty = 1'b0; abort = 1'b0;
        for (int c = 0; c < 200 && ticks < 33; c++) begin
            drive_baud();
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== exp_v[k]) begin
                    n_err++;
                    $display("FAIL b2b dut%0d t=%0t got %b want %b", k, $time, obs[k], exp_v[k]);
                end
            end
            if (baud) begin
                ticks++;
                if (!obs[0][0]) idle_ticks++;
            end
            if (obs[0][1]) dones++;
        end
        n_cmp++;
        if (ticks != 33) begin n_err++; $display("FAIL b2b_tick_budget got %0d want 33", ticks); end
        n_cmp++;
        if (dones != 3) begin n_err++; $display("FAIL b2b_done_count got %0d want 3", dones); end
        n_cmp++;
        if (idle_ticks != 3) begin n_err++; $display("FAIL b2b_idle_ticks got %0d want 3", idle_ticks); end
        drain("b2b");
    endtask

    task automatic test_abort();
        bit ab_done = 1'b0;
        int stop_ticks = 0, dones = 0, maxcnt = 0;
        par_en = 1'b0; two_stop = 1'b1; fifo_empty = 1'b0;
        for (int c = 0; c < 100; c++) begin
            abort = 1'b0;
            drive_baud();
            if (!ab_done && obs[0][11:7] == 5'b00100 && obs[0][6:3] == 4'd3) begin
                abort = 1'b1; ab_done = 1'b1;
            end
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== exp_v[k]) begin
                    n_err++;
                    $display("FAIL abort_frame dut%0d t=%0t got %b want %b", k, $time, obs[k], exp_v[k]);
                end
            end
            if (obs[0][0]) fifo_empty = 1'b1;
            if (baud && obs[0][11:7] == 5'b10000) stop_ticks++;
            if (obs[0][1]) dones++;
        end
        n_cmp++;
        if (!ab_done) begin n_err++; $display("FAIL abort_reached_bit3 got 0 want 1"); end
        n_cmp++;
        if (stop_ticks != 2) begin n_err++; $display("FAIL abort_stop_ticks got %0d want 2", stop_ticks); end
        n_cmp++;
        if (dones != 1) begin n_err++; $display("FAIL abort_done_count got %0d want 1", dones); end
        // Abort while idle must not shorten the following frame.
        two_stop = 1'b0; fifo_empty = 1'b1; abort = 1'b0;
        baud = 1'b0; step();
        abort = 1'b1; step();
        abort = 1'b0;
        repeat (8) begin drive_baud(); step(); end
        fifo_empty = 1'b0; dones = 0;
        for (int c = 0; c < 80; c++) begin
            drive_baud();
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== exp_v[k]) begin
                    n_err++;
                    $display("FAIL abort_idle dut%0d t=%0t got %b want %b", k, $time, obs[k], exp_v[k]);
                end
            end
            if (obs[0][0]) fifo_empty = 1'b1;
            if (obs[0][1]) dones++;
            if (obs[0][11:7] == 5'b00100 && int'(obs[0][6:3]) > maxcnt) maxcnt = int'(obs[0][6:3]);
        end
        n_cmp++;
        if (maxcnt != 7) begin n_err++; $display("FAIL abort_idle_full_frame got %0d want 7", maxcnt); end
        drain("abort");
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        par_en = 1'b0; two_stop = 1'b0; fifo_empty = 1'b0; abort = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            drive_baud();
            if (obs[0][11:7] == 5'b00100 && obs[0][6:3] == 4'd4) begin
                baud = 1'b1; rst = 1'b1; hit = 1'b1;
            end
            step();
            if (obs[0][0]) fifo_empty = 1'b1;
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== IDLE_V || obs[k] !== exp_v[k]) begin
                n_err++;
                $display("FAIL reset_mid dut%0d got %b want %b", k, obs[k], IDLE_V);
            end
        end
        n_cmp++;
        if (!hit) begin n_err++; $display("FAIL reset_mid_reached got 0 want 1"); end
        drain("reset_mid");
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            baud = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) fifo_empty = ~fifo_empty;
            if ($urandom_range(0, 15) == 0) par_en = ~par_en;
            if ($urandom_range(0, 15) == 0) two_stop = ~two_stop;
            abort = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 599) == 0);
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== exp_v[k]) begin
                    n_err++;
                    $display("FAIL random dut%0d t=%0t got %b want %b", k, $time, obs[k], exp_v[k]);
                end
            end
        end
        rst = 1'b0;
        drain("random");
    endtask

    initial begin
        rst = 1'b1; baud = 1'b0; fifo_empty = 1'b1; par_en = 1'b0; two_stop = 1'b0; abort = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_parity_two_stop();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
